// File: rtl/im_loader_if.sv
// Byte-stream and instruction-memory write bundle for im_loader.
// slave: the loader side; master: byte source plus memory write sink.
interface im_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_byte, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: big-endian byte packer, sequential word writer.
// Define IM_LOADER_CHECKSUM_EN to require a zero-sum 4-byte trailer.
module im_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  im_loader_if.slave      bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W:0] MAX_W = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] WC_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] WA_ONE = ADDR_W'(1);

  state_t            state, state_d;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       wbuf;
  logic              last_seen;
  logic              hs;
  logic              word_end;
  logic              restart;
  logic              trail;
  logic              sum_ok;

  assign hs       = (state == LOAD) && bus.in_valid;
  assign word_end = hs && (byte_cnt == 2'd3);
  assign restart  = start &&
                    ((state == IDLE) ||
                     (state == DONE) ||
                     (state == ERR));

`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
  logic [31:0] sum;

  // trail marks that the image words are done and the trailer is streaming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      trail <= 1'b0;
    end else if (restart) begin
      sum   <= '0;
      trail <= 1'b0;
    end else if (state == WRITE) begin
      sum <= sum + wbuf;
      if (last_seen) trail <= 1'b1;
    end
  end

  assign sum_ok = (sum + {wbuf[23:0], bus.in_byte}) == 32'h0;
`else
  localparam bit CHK = 1'b0;
  assign trail  = 1'b0;
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (word_end) begin
          if (trail) state_d = sum_ok ? DONE : ERR;
          else       state_d = WRITE;
        end else if (hs && bus.in_last && !trail) begin
          state_d = ERR;
        end
      end
      WRITE: begin
        if (last_seen)
          state_d = CHK ? LOAD : DONE;
        else if (word_count + WC_ONE == MAX_W)
          state_d = ERR;
        else
          state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      word_addr  <= '0;
      word_count <= '0;
      wbuf       <= '0;
      last_seen  <= 1'b0;
    end else begin
      if (restart) begin
        byte_cnt   <= '0;
        word_addr  <= '0;
        word_count <= '0;
        last_seen  <= 1'b0;
      end
      if (hs) begin
        wbuf     <= {wbuf[23:0], bus.in_byte};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3)
          last_seen <= bus.in_last && !trail;
      end
      if (state == WRITE) begin
        word_addr  <= word_addr + WA_ONE;
        word_count <= word_count + WC_ONE;
      end
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = word_addr;
  assign bus.mem_wdata = wbuf;

  assign cpu_hold = (state == LOAD) ||
                    (state == WRITE) ||
                    (state == ERR);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader (MAX_WORDS=4 instance).
// Expected writes are queued by stimulus and checked by a write monitor.
module tb_im_loader;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cpu_hold;
  logic       done;
  logic       err;
  logic [8:0] word_count;

  int total;
  int bad;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [7:0]  exp_addr;
  logic [31:0] img_sum;

  im_loader_if #(.ADDR_W(8)) bus ();

  im_loader #(
    .ADDR_W(8),
    .MAX_WORDS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, want none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(e.a));
        chk("wr_data", 64'(bus.mem_wdata), 64'(e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic l,
                           input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = l;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL handshake: in_ready 0 after 50 cycles, want 1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l,
                           input int gap, input bit wr);
    logic [31:0] t;
    t = w;
    if (wr) begin
      sb.push_back('{a: exp_addr, d: w});
      exp_addr++;
      img_sum += w;
    end
    send_byte(t[31:24], 1'b0, gap);
    send_byte(t[23:16], 1'b0, gap);
    send_byte(t[15:8],  1'b0, gap);
    send_byte(t[7:0],   l,    gap);
  endtask

  task automatic finish_image();
`ifdef IM_LOADER_CHECKSUM_EN
    send_word(32'h0 - img_sum, 1'b0, 0, 1'b0);
`endif
  endtask

  task automatic start_load();
    exp_addr = 8'd0;
    img_sum  = 32'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) begin
      total++;
      bad++;
      $display("FAIL end_timeout: done/err 0 after 40 cycles, want 1");
    end
  endtask

  task automatic status(input string nm, input logic d, input logic e,
                        input int wc, input logic h);
    chk({nm, "_done"}, 64'(done), 64'(d));
    chk({nm, "_err"},  64'(err), 64'(e));
    chk({nm, "_wc"},   64'(word_count), 64'(wc));
    chk({nm, "_hold"}, 64'(cpu_hold), 64'(h));
    chk({nm, "_rdy"},  64'(bus.in_ready), 64'(0));
  endtask

  task automatic all_zero(input string nm);
    chk(nm, {bus.in_ready, bus.mem_we, cpu_hold, done, err,
             bus.mem_addr, bus.mem_wdata, word_count}, 64'(0));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    exp_addr     = 8'd0;
    img_sum      = 32'd0;
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'd0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    all_zero("idle_outputs");

    // single word
    start_load();
    chk("t1_hold", 64'(cpu_hold), 64'(1));
    chk("t1_rdy", 64'(bus.in_ready), 64'(1));
    send_byte(8'h20, 1'b0, 0);
    sb.push_back('{a: 8'd0, d: 32'h20080005});
    img_sum = 32'h20080005;
    send_byte(8'h08, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h05, 1'b1, 0);
    chk("t1_we", 64'(bus.mem_we), 64'(1));
    finish_image();
    wait_end();
    status("t1", 1'b1, 1'b0, 1, 1'b0);

    // three words, in_valid toggling
    start_load();
    send_word(32'h3C011000, 1'b0, 1, 1'b1);
    send_word(32'h8C220004, 1'b0, 1, 1'b1);
    send_word(32'hAC220008, 1'b1, 1, 1'b1);
    finish_image();
    wait_end();
    status("t2", 1'b1, 1'b0, 3, 1'b0);

    // in_last on the 6th byte
    start_load();
    send_word(32'h11223344, 1'b0, 0, 1'b1);
    send_byte(8'h55, 1'b0, 0);
    send_byte(8'h66, 1'b1, 0);
    wait_end();
    status("t3", 1'b0, 1'b1, 1, 1'b1);
    start_load();
    send_word(32'hCAFEF00D, 1'b1, 0, 1'b1);
    finish_image();
    wait_end();
    status("t3_reload", 1'b1, 1'b0, 1, 1'b0);

    // overflow at MAX_WORDS=4
    start_load();
    send_word(32'h00000010, 1'b0, 0, 1'b1);
    send_word(32'h00000020, 1'b0, 0, 1'b1);
    send_word(32'h00000030, 1'b0, 0, 1'b1);
    send_word(32'h00000040, 1'b0, 0, 1'b1);
    wait_end();
    status("t4", 1'b0, 1'b1, 4, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("t4_byte17_rdy", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid = 1'b0;

    // async reset mid-load
    start_load();
    send_byte(8'hDE, 1'b0, 0);
    send_byte(8'hAD, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1 all_zero("t5_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_load();
    send_word(32'h0BADBEEF, 1'b1, 0, 1'b1);
    finish_image();
    wait_end();
    status("t5_restart", 1'b1, 1'b0, 1, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
    start_load();
    send_word(32'h00000001, 1'b0, 0, 1'b1);
    send_word(32'h00000002, 1'b1, 0, 1'b1);
    send_word(32'hFFFFFFFD, 1'b0, 0, 1'b0);
    wait_end();
    status("t6_sum_ok", 1'b1, 1'b0, 2, 1'b0);
    start_load();
    send_word(32'h00000001, 1'b0, 0, 1'b1);
    send_word(32'h00000002, 1'b1, 0, 1'b1);
    send_word(32'hFFFFFFFC, 1'b0, 0, 1'b0);
    wait_end();
    status("t6_sum_bad", 1'b0, 1'b1, 2, 1'b1);
`else
    start_load();
    send_word(32'h00000001, 1'b0, 0, 1'b1);
    send_word(32'h00000002, 1'b1, 0, 1'b1);
    wait_end();
    status("t6_two", 1'b1, 1'b0, 2, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/im_loader.md
# im_loader

Instruction-memory loader for the multicycle MIPS core. It accepts a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words. It writes those words sequentially from word address 0 into the instruction memory write port. While loading, it holds the CPU stalled; this block is the writer paired with the combinational instruction-fetch read port.

## Interface
- ADDR_W, 8, word-address width of instruction memory (256 words)
- MAX_WORDS, 256, capacity in words; must be ≤ 2^ADDR_W

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a load (ignored in LOAD/WRITE)
- in_valid  in  1  byte source has data
- in_ready  out  1  loader accepts a byte this cycle
- in_byte  in  8  stream byte
- in_last  in  1  qualifies final byte of image (sampled with the handshake)
- mem_we  out  1  instruction-memory write enable, one cycle per word
- mem_addr  out  ADDR_W  word address (byte address >> 2)
- mem_wdata  out  32  packed word
- cpu_hold  out  1  stall request to the CPU/PC register
- done  out  1  image loaded successfully
- err  out  1  load aborted (overflow, partial word, or checksum)
- word_count  out  ADDR_W+1  words written in the current or last load

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE: in_ready=0, cpu_hold=0. On start: go to LOAD, clear byte_cnt, word_addr, word_count, done, err; assert cpu_hold.
- LOAD: in_ready=1. On in_valid&&in_ready, shift in_byte into the word buffer (buf <= {buf[23:0], in_byte}, so the first byte lands in [31:24]), and increment the 2-bit byte_cnt.
  - 4th byte accepted: go to WRITE; latch last_seen=in_last.
  - in_last on bytes 1–3: go to ERR; the partial word is discarded and never written.
- WRITE (one cycle): mem_we=1, mem_addr=word_addr, mem_wdata=buf, in_ready=0. Then increment word_addr and word_count.
  - last_seen: go to DONE.
  - Else, if word_count after increment == MAX_WORDS: go to ERR (overflow).
  - Else: go to LOAD.
- DONE: done=1, cpu_hold=0, in_ready=0. start begins a reload.
- ERR: err=1, cpu_hold=1 (CPU stays stalled), in_ready=0. start restarts the load.
- mem_addr/mem_wdata are don't-care when mem_we=0, but are held registered (no glitches).
- Memory contents beyond the last written word are untouched.

## Timing
- Reset (async assert): state=IDLE. in_ready, mem_we, cpu_hold, done, err = 0. mem_addr, mem_wdata, word_count = 0. Release is synchronous to clk.
- All outputs are registered or decoded from the registered state only; there is no combinational path from inputs to outputs.
- Best throughput is 4 bytes per 5 cycles: 4 LOAD handshakes, then 1 WRITE bubble with in_ready=0.
- mem_we rises the cycle after the 4th byte handshake edge; the write commits at the following edge.
- cpu_hold rises the cycle after start is sampled in IDLE/DONE/ERR. It falls on entry to DONE, the same edge that sets done.
- start coincident with the final WRITE cycle is ignored.
- in_valid stalls in LOAD: state and byte_cnt hold indefinitely.
- rst_n asserted mid-load: the load is abandoned immediately. Already-written words remain in memory, and no further write occurs.

## Configuration
- IM_LOADER_CHECKSUM_EN defined:
  - The loader keeps a 32-bit wrapping sum of written words.
  - After the word carrying in_last, exactly one further 4-byte trailer is consumed. The trailer is not written to memory and does not count in word_count.
  - Passing requires sum + trailer == 32'h0; then go to DONE, otherwise go to ERR.
  - in_last is ignored on trailer bytes.
- Undefined: no trailer and no sum logic; DONE follows the last word's WRITE directly.

## Test plan
- Reset then start, stream bytes 20,08,00,05 with in_last on 05 → one mem_we with addr 0, wdata 32'h20080005; done=1, word_count=1, cpu_hold low after DONE entry.
- 3-word image with in_valid toggled every other cycle → writes at addr 0,1,2 in order, no lost or duplicated bytes, done=1, word_count=3.
- in_last on the 6th byte → exactly one write (addr 0); err=1, cpu_hold stays 1, done=0; start then reloads cleanly.
- MAX_WORDS=4, 16 bytes with no in_last → 4 writes (addr 0–3), then err=1; the 17th byte sees in_ready=0.
- rst_n pulsed low after 2 bytes of word 1 → all outputs 0 asynchronously, no mem_we; restart loads from addr 0.
- With IM_LOADER_CHECKSUM_EN, words 32'h00000001 and 32'h00000002, trailer 32'hFFFFFFFD → done=1, word_count=2. Repeat with trailer 32'hFFFFFFFC → err=1.
